// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage signed DSP slice.
//   stage 1  operand registers (B register doubles as the BCOUT cascade)
//   stage 2  pre-adder feeding a full-width signed multiplier, product in M
//   stage 3  post-adder / accumulator into P, with carry, overflow and
//            optional saturation
// An in-band valid bit travels alongside the operands. P only changes on
// valid cycles, so bubbles never re-accumulate. CE freezes the whole pipe.
module dsp_mac_pipe #(
  parameter int A_WIDTH  = 18,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 48,
  parameter bit SATURATE = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       IN_VALID,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  input  logic [B_WIDTH-1:0]         D,
  input  logic [P_WIDTH-1:0]         C,
  input  logic                       CARRYIN,
  input  logic [4:0]                 OPMODE,
  output logic [B_WIDTH-1:0]         BCOUT,
  output logic [A_WIDTH+B_WIDTH-1:0] M,
  output logic [P_WIDTH-1:0]         P,
  output logic                       CARRYOUT,
  output logic                       OVERFLOW,
  output logic                       OUT_VALID
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;

  // OPMODE field positions
  localparam int OP_PRE_EN   = 0;
  localparam int OP_PRE_SUB  = 1;
  localparam int OP_POST_SUB = 4;

  typedef enum logic [1:0] {
    ZSEL_ZERO  = 2'b00,
    ZSEL_C     = 2'b01,
    ZSEL_P     = 2'b10,
    ZSEL_ZERO2 = 2'b11
  } zsel_e;

  // Stage 1 registers
  logic [A_WIDTH-1:0] a1_q;
  logic [B_WIDTH-1:0] b1_q, d1_q;
  logic [P_WIDTH-1:0] c1_q;
  logic               cin1_q, v1_q;
  logic [4:0]         op1_q;

  // Stage 2 registers
  logic [M_WIDTH-1:0] m_q;
  logic [P_WIDTH-1:0] c2_q;
  logic               cin2_q, v2_q;
  logic [4:0]         op2_q;

  // Stage 3 registers
  logic [P_WIDTH-1:0] p_q;
  logic               co_q, ovf_q, out_valid_q;

  // Stage 1: capture operands and the valid bit
  // NOTE: every clocked assignment is non-blocking so all stages sample the
  // pre-edge values of the stage before them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a1_q   <= '0;
      b1_q   <= '0;
      d1_q   <= '0;
      c1_q   <= '0;
      cin1_q <= 1'b0;
      op1_q  <= '0;
      v1_q   <= 1'b0;
    end else if (CE) begin
      a1_q   <= A;
      b1_q   <= B;
      d1_q   <= D;
      c1_q   <= C;
      cin1_q <= CARRYIN;
      op1_q  <= OPMODE;
      v1_q   <= IN_VALID;
    end
  end

  // Stage 2 combinational: wrapping pre-adder, then sign-extended multiply
  logic [B_WIDTH-1:0] pre_d;
  logic [M_WIDTH-1:0] a_ext, pre_ext, m_d;

  // NOTE: each always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pre_d = b1_q;
    if (op1_q[OP_PRE_EN]) begin
      pre_d = op1_q[OP_PRE_SUB] ? (d1_q - b1_q) : (d1_q + b1_q);
    end
    // Low M_WIDTH bits of an unsigned product of sign-extended operands
    // equal the signed product.
    a_ext   = {{B_WIDTH{a1_q[A_WIDTH-1]}}, a1_q};
    pre_ext = {{A_WIDTH{pre_d[B_WIDTH-1]}}, pre_d};
    m_d     = a_ext * pre_ext;
  end

  // Stage 2: product register (updates on bubbles too) and side-band forward
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_q    <= '0;
      c2_q   <= '0;
      cin2_q <= 1'b0;
      op2_q  <= '0;
      v2_q   <= 1'b0;
    end else if (CE) begin
      m_q    <= m_d;
      c2_q   <= c1_q;
      cin2_q <= cin1_q;
      op2_q  <= op1_q;
      v2_q   <= v1_q;
    end
  end

  // Stage 3 combinational: Z mux, post add/sub, carry, overflow, saturation
  logic [P_WIDTH-1:0] z_d, msx_d, y_mag_d, y_d, r_d, p_d;
  logic [P_WIDTH:0]   s_d;
  logic               co_d, ovf_d;

  always_comb begin
    case (zsel_e'(op2_q[3:2]))
      ZSEL_C:  z_d = c2_q;
      ZSEL_P:  z_d = p_q;   // feedback from the P register: no accumulate hazard
      default: z_d = '0;
    endcase
    msx_d = {{(P_WIDTH-M_WIDTH){m_q[M_WIDTH-1]}}, m_q};
    if (op2_q[OP_POST_SUB]) begin
      s_d = {1'b0, z_d} - ({1'b0, msx_d} + {{P_WIDTH{1'b0}}, cin2_q});
    end else begin
      s_d = {1'b0, z_d} + {1'b0, msx_d} + {{P_WIDTH{1'b0}}, cin2_q};
    end
    r_d  = s_d[P_WIDTH-1:0];
    co_d = s_d[P_WIDTH];
    // The second addend as actually added to Z; Msx+CIN cannot overflow
    // because P_WIDTH exceeds the product width.
    y_mag_d = msx_d + {{(P_WIDTH-1){1'b0}}, cin2_q};
    y_d     = op2_q[OP_POST_SUB] ? -y_mag_d : y_mag_d;
    ovf_d   = (z_d[P_WIDTH-1] == y_d[P_WIDTH-1]) &&
              (r_d[P_WIDTH-1] != z_d[P_WIDTH-1]);
    p_d = r_d;
    if (SATURATE && ovf_d) begin
      p_d = z_d[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                           : {1'b0, {(P_WIDTH-1){1'b1}}};
    end
  end

  // Stage 3: result registers write only on valid; OUT_VALID tracks v2
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        p_q   <= p_d;
        co_q  <= co_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign BCOUT     = b1_q;
  assign M         = m_q;
  assign P         = p_q;
  assign CARRYOUT  = co_q;
  assign OVERFLOW  = ovf_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Testbench for dsp_mac_pipe: a wrapping and a saturating instance share all
// inputs. Single-transaction vectors come from a table; reset, accumulate and
// stall behaviour are exercised by hand-written sequences.
module tb_dsp_mac_pipe;

  logic        CLK = 1'b0;
  logic        RST, CE, IN_VALID, CARRYIN;
  logic [17:0] A, B, D;
  logic [47:0] C;
  logic [4:0]  OPMODE;

  logic [17:0] bcout_w, bcout_s;
  logic [35:0] m_w, m_s;
  logic [47:0] p_w, p_s;
  logic        co_w, co_s, ovf_w, ovf_s, ov_w, ov_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(bcout_w), .M(m_w), .P(p_w), .CARRYOUT(co_w),
    .OVERFLOW(ovf_w), .OUT_VALID(ov_w)
  );

  dsp_mac_pipe #(.A_WIDTH(18), .B_WIDTH(18), .P_WIDTH(48), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .BCOUT(bcout_s), .M(m_s), .P(p_s), .CARRYOUT(co_s),
    .OVERFLOW(ovf_s), .OUT_VALID(ov_s)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic        cin;
    logic [35:0] em;
    logic [47:0] ep;    // expected P, wrapping instance
    logic [47:0] eps;   // expected P, saturating instance
    logic        eco;
    logic        eov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then settle outputs before sampling or driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // op[0] PRE_EN, op[1] PRE_SUB, op[3:2] ZSEL, op[4] POST_SUB
    vecs[0] = '{"mult",      5'b00000, 18'd3,      18'd5,      18'd0,      48'd0,
                1'b0, 36'd15,            48'd15,            48'd15,            1'b0, 1'b0};
    vecs[1] = '{"presub",    5'b00011, -18'sd2,    18'd4,      18'd10,     48'd12345,
                1'b0, -36'sd12,          -48'sd12,          -48'sd12,          1'b0, 1'b0};
    vecs[2] = '{"presub_c",  5'b00111, -18'sd2,    18'd4,      18'd10,     48'd100,
                1'b1, -36'sd12,          48'd89,            48'd89,            1'b1, 1'b0};
    vecs[3] = '{"ovf_pos",   5'b00100, 18'd1,      18'd1,      18'd0,      48'h7FFF_FFFF_FFFF,
                1'b0, 36'd1,             48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[4] = '{"preadd",    5'b00001, 18'd5,      -18'sd3,    18'd7,      48'd777,
                1'b0, 36'd20,            48'd20,            48'd20,            1'b0, 1'b0};
    vecs[5] = '{"postsub",   5'b10100, 18'd4,      18'd3,      18'd0,      48'd50,
                1'b1, 36'd12,            48'd37,            48'd37,            1'b0, 1'b0};
    vecs[6] = '{"ovf_neg",   5'b10100, 18'd1,      18'd1,      18'd0,      48'h8000_0000_0000,
                1'b0, 36'd1,             48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b0, 1'b1};
    vecs[7] = '{"zsel11",    5'b01100, -18'sd3,    18'd7,      18'd0,      48'd999,
                1'b0, -36'sd21,          -48'sd21,          -48'sd21,          1'b0, 1'b0};
    vecs[8] = '{"pre_wrap",  5'b00001, 18'd1,      18'd1,      18'd131071, 48'd0,
                1'b0, -36'sd131072,      -48'sd131072,      -48'sd131072,      1'b0, 1'b0};
    vecs[9] = '{"max_prod",  5'b00000, 18'h20000,  18'h20000,  18'd0,      48'd0,
                1'b0, 36'h4_0000_0000,   48'h4_0000_0000,   48'h4_0000_0000,   1'b0, 1'b0};

    RST = 1'b1; CE = 1'b1; IN_VALID = 1'b0; CARRYIN = 1'b0;
    A = '0; B = '0; D = '0; C = '0; OPMODE = '0;

    // ---- Reset with random, valid-marked inputs for 2 cycles ----
    for (int k = 0; k < 2; k++) begin
      IN_VALID = 1'b1;
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
      C = {16'($urandom), 32'($urandom)};
      CARRYIN = 1'($urandom); OPMODE = 5'($urandom);
      step();
    end
    check("rst_P",        p_w,     64'd0);
    check("rst_M",        m_w,     64'd0);
    check("rst_BCOUT",    bcout_w, 64'd0);
    check("rst_OUTVALID", ov_w,    64'd0);
    check("rst_CARRYOUT", co_w,    64'd0);
    check("rst_OVERFLOW", ovf_w,   64'd0);
    RST = 1'b0; IN_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_flush_OUTVALID_%0d", k), ov_w, 64'd0);
    end

    // ---- Table-driven single transactions ----
    foreach (vecs[i]) begin
      A = vecs[i].a; B = vecs[i].b; D = vecs[i].d; C = vecs[i].c;
      CARRYIN = vecs[i].cin; OPMODE = vecs[i].op; IN_VALID = 1'b1;
      step();                                     // edge 1
      check({vecs[i].name, "_BCOUT"}, bcout_w, {46'd0, vecs[i].b});
      IN_VALID = 1'b0;
      step();                                     // edge 2
      check({vecs[i].name, "_M"}, m_w, {28'd0, vecs[i].em});
      check({vecs[i].name, "_OUTVALID_early"}, ov_w, 64'd0);
      step();                                     // edge 3
      check({vecs[i].name, "_P"},        p_w,   {16'd0, vecs[i].ep});
      check({vecs[i].name, "_P_sat"},    p_s,   {16'd0, vecs[i].eps});
      check({vecs[i].name, "_CARRYOUT"}, co_w,  {63'd0, vecs[i].eco});
      check({vecs[i].name, "_OVERFLOW"}, ovf_w, {63'd0, vecs[i].eov});
      check({vecs[i].name, "_OVF_sat"},  ovf_s, {63'd0, vecs[i].eov});
      check({vecs[i].name, "_OUTVALID"}, ov_w,  64'd1);
      step();                                     // edge 4
      check({vecs[i].name, "_OUTVALID_1cyc"}, ov_w, 64'd0);
      check({vecs[i].name, "_P_hold"}, p_w, {16'd0, vecs[i].ep});
    end

    // ---- Accumulate: 4 valids then 2 bubbles, starting from P=0 ----
    RST = 1'b1; step(); RST = 1'b0;
    A = 18'd2; B = 18'd3; D = '0; C = 48'd5555; CARRYIN = 1'b0;
    OPMODE = 5'b01000; IN_VALID = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [47:0] exp_p;
      logic        exp_v;
      step();
      if (k == 4) IN_VALID = 1'b0;
      exp_p = (k < 3) ? 48'd0 : (k <= 6) ? 48'(6 * (k - 2)) : 48'd24;
      exp_v = (k >= 3 && k <= 6);
      check($sformatf("acc_P_e%0d", k),        p_w,  {16'd0, exp_p});
      check($sformatf("acc_OUTVALID_e%0d", k), ov_w, {63'd0, exp_v});
    end

    // ---- Stall: valid at cycle 0, CE=0 on cycles 1-2 ----
    A = 18'd6; B = 18'd7; OPMODE = 5'b00000; IN_VALID = 1'b1; CE = 1'b1;
    step();                                       // edge 1
    IN_VALID = 1'b0; CE = 1'b0; B = 18'd9;
    for (int k = 2; k <= 3; k++) begin
      step();
      check($sformatf("stall_OUTVALID_e%0d", k), ov_w,    64'd0);
      check($sformatf("stall_BCOUT_e%0d", k),    bcout_w, 64'd7);
      check($sformatf("stall_P_hold_e%0d", k),   p_w,     64'd24);
    end
    CE = 1'b1;
    step();                                       // edge 4
    check("stall_OUTVALID_e4", ov_w, 64'd0);
    step();                                       // edge 5
    check("stall_OUTVALID_e5", ov_w, 64'd1);
    check("stall_P_e5",        p_w,  64'd42);
    step();
    check("stall_OUTVALID_e6", ov_w, 64'd0);

    // ---- Reset during a stall discards the in-flight operand ----
    A = 18'd6; B = 18'd7; IN_VALID = 1'b1; CE = 1'b1;
    step();                                       // edge 1
    IN_VALID = 1'b0; CE = 1'b0;
    step();                                       // edge 2 (stalled)
    RST = 1'b1;
    step();                                       // edge 3 (stalled, reset)
    RST = 1'b0; CE = 1'b1;
    check("stallrst_P_e3", p_w, 64'd0);
    check("stallrst_M_e3", m_w, 64'd0);
    for (int k = 4; k <= 7; k++) begin
      step();
      check($sformatf("stallrst_OUTVALID_e%0d", k), ov_w, 64'd0);
      check($sformatf("stallrst_P_e%0d", k),        p_w,  64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
